demux_1_n_stream: RTL

DEMUX_1_N_STREAM -- requirements
Module: demux_1_n_stream

---
 rtl/demux_1_n_stream.sv | 90 +++++++++
 1 files changed

// File: rtl/demux_1_n_stream.sv
// One-to-N stream demultiplexer. Each output channel has a single-entry register.
// A beat goes to one channel, or to all channels together. A beat whose select is out of range is dropped and counted.
module demux_1_n_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N),
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_bcast,
   output logic [N-1:0]         out_valid,
   input  logic [N-1:0]         out_ready,
   output logic [N*WIDTH-1:0]   out_data,
   output logic                 err,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int NP = 1 << SEL_W;
   localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

   logic [N-1:0]            valid_q;
   logic [N-1:0][WIDTH-1:0] data_q;
   logic [N-1:0]            free;
   logic [NP-1:0]           free_pad;
   logic [N-1:0]            load;
   logic                    in_range;
   logic                    xfer;
   logic                    drop;

   assign free     = ~valid_q | out_ready;
   assign in_range = ({1'b0, in_sel} < N_EXT);

   // Pad to the full select range so that indexing with any in_sel value stays in bounds.
   always_comb begin
      free_pad = '0;
      for (int k = 0; k < N; k++) free_pad[k] = free[k];
   end

   always_comb begin
      in_ready = 1'b1;
      if (in_bcast)      in_ready = &free;
      else if (in_range) in_ready = free_pad[in_sel];
   end

   assign xfer = in_valid & in_ready;
   assign drop = xfer & ~in_bcast & ~in_range;

   always_comb begin
      load = '0;
      for (int k = 0; k < N; k++)
         load[k] = xfer & (in_bcast | (in_range & (in_sel == SEL_W'(k))));
   end

   // When a channel is loaded and drained in the same cycle, the load takes priority so the channel keeps full throughput.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (load[k]) begin
               valid_q[k] <= 1'b1;
               data_q[k]  <= in_data;
            end else if (out_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         err <= drop;
         if (drop && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule
